// File: rtl/banked_data_memory.sv
// Multi-port, byte-enabled data memory for the VLIW MEM stage. It runs a clear sweep after
// every reset and has a fixed-latency read pipeline that returns the word as it was before same-cycle writes.
module banked_data_memory #(
   parameter int                DATA_W     = 32,
   parameter int                DEPTH      = 1024,
   parameter int                NUM_PORTS  = 2,
   parameter int                READ_LAT   = 1,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0,
   localparam int               AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int               BW         = DATA_W / 8
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          ready,
   input  logic [NUM_PORTS-1:0]          req_valid,
   input  logic [NUM_PORTS-1:0]          req_we,
   input  logic [NUM_PORTS*AW-1:0]       req_addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
   input  logic [NUM_PORTS*BW-1:0]       req_be,
   output logic [NUM_PORTS-1:0]          rsp_valid,
   output logic [NUM_PORTS*DATA_W-1:0]   rsp_rdata,
   output logic [NUM_PORTS-1:0]          rsp_err
);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                       state_q;
   logic [AW-1:0]                clear_ptr_q;
   logic                         ready_q;

   logic [DATA_W-1:0]            mem [DEPTH];

   logic [NUM_PORTS-1:0]         in_range;
   logic [NUM_PORTS-1:0]         wr_acc;
   logic [NUM_PORTS-1:0]         rd_vld_d;
   logic [NUM_PORTS-1:0]         rd_err_d;
   logic [NUM_PORTS*DATA_W-1:0]  rd_data_d;

   logic [NUM_PORTS-1:0]         vld_q  [READ_LAT];
   logic [NUM_PORTS-1:0]         err_q  [READ_LAT];
   logic [NUM_PORTS*DATA_W-1:0]  data_q [READ_LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= CLEAR;
         clear_ptr_q <= '0;
         ready_q     <= 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               clear_ptr_q <= clear_ptr_q + AW'(1);
               if (clear_ptr_q == AW'(DEPTH - 1)) begin
                  state_q     <= RUN;
                  ready_q     <= 1'b1;
                  clear_ptr_q <= '0;
               end
            end
            RUN: begin
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= CLEAR;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Stage 0: decode and acceptance; read data is taken from the array before this edge's writes.
   always_comb begin
      in_range  = '0;
      wr_acc    = '0;
      rd_vld_d  = '0;
      rd_err_d  = '0;
      rd_data_d = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         in_range[p] = ({1'b0, req_addr[p*AW +: AW]} < (AW+1)'(DEPTH));
         wr_acc[p]   = ready_q & req_valid[p] & req_we[p] & in_range[p];
         if (ready_q && req_valid[p] && !req_we[p]) begin
            rd_vld_d[p] = 1'b1;
            rd_err_d[p] = ~in_range[p];
            if (in_range[p]) begin
               rd_data_d[p*DATA_W +: DATA_W] = mem[req_addr[p*AW +: AW]];
            end
         end
      end
   end

   // Later ports issue their byte writes after earlier ones, so the highest slot owns a shared lane.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         mem[clear_ptr_q] <= INIT_VALUE;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            for (int b = 0; b < BW; b++) begin
               if (wr_acc[p] && req_be[p*BW + b]) begin
                  mem[req_addr[p*AW +: AW]][b*8 +: 8] <= req_wdata[p*DATA_W + b*8 +: 8];
               end
            end
         end
      end
   end

   // Stages 1..READ_LAT-1: delay line; reset flushes every stage so no stale response survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < READ_LAT; s++) begin
            vld_q[s]  <= '0;
            err_q[s]  <= '0;
            data_q[s] <= '0;
         end
      end else begin
         vld_q[0]  <= rd_vld_d;
         err_q[0]  <= rd_err_d;
         data_q[0] <= rd_data_d;
         for (int s = 1; s < READ_LAT; s++) begin
            vld_q[s]  <= vld_q[s-1];
            err_q[s]  <= err_q[s-1];
            data_q[s] <= data_q[s-1];
         end
      end
   end

   assign ready     = ready_q;
   assign rsp_valid = vld_q[READ_LAT-1];
   assign rsp_err   = err_q[READ_LAT-1];
   assign rsp_rdata = data_q[READ_LAT-1];

endmodule

// File: tb/tb_banked_data_memory.sv
// Directed bench for banked_data_memory: instance 0 (DEPTH 16, latency 1, init 0) and
// instance 1 (DEPTH 12, latency 3, non-zero init), checked against a reference model and response scoreboard.
module tb_banked_data_memory;
   localparam int DW = 32;
   localparam int NP = 2;
   localparam int AW = 4;
   localparam int BW = 4;
   localparam logic [31:0] INIT_B = 32'hA5A5_0F0F;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst       [2];
   logic [NP-1:0]     req_valid [2];
   logic [NP-1:0]     req_we    [2];
   logic [NP*AW-1:0]  req_addr  [2];
   logic [NP*DW-1:0]  req_wdata [2];
   logic [NP*BW-1:0]  req_be    [2];
   logic              ready     [2];
   logic [NP-1:0]     rsp_valid [2];
   logic [NP-1:0]     rsp_err   [2];
   logic [NP*DW-1:0]  rsp_rdata [2];

   banked_data_memory #(.DATA_W(32), .DEPTH(16), .NUM_PORTS(2), .READ_LAT(1), .INIT_VALUE(32'h0)) u_a (
      .clk(clk), .rst(rst[0]), .ready(ready[0]),
      .req_valid(req_valid[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .req_be(req_be[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

   banked_data_memory #(.DATA_W(32), .DEPTH(12), .NUM_PORTS(2), .READ_LAT(3), .INIT_VALUE(INIT_B)) u_b (
      .clk(clk), .rst(rst[1]), .ready(ready[1]),
      .req_valid(req_valid[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .req_be(req_be[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

   typedef struct {
      int          inst;
      int          port;
      int          due;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] mm [2][16];
   int          mcnt [2];
   bit          mrdy [2];
   int          cyc;
   int          errors;
   int          checks;

   function automatic int dep(input int i);
      return (i == 0) ? 16 : 12;
   endfunction

   function automatic int lat(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] initv(input int i);
      return (i == 0) ? 32'h0 : INIT_B;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = '0;
         req_we[i]    = '0;
         req_addr[i]  = '0;
         req_wdata[i] = '0;
         req_be[i]    = '0;
      end
   endtask

   task automatic rd(input int i, input int p, input int a);
      req_valid[i][p]       = 1'b1;
      req_we[i][p]          = 1'b0;
      req_addr[i][p*AW +: AW] = AW'(a);
   endtask

   task automatic wr(input int i, input int p, input int a, input logic [31:0] d, input logic [3:0] be);
      req_valid[i][p]          = 1'b1;
      req_we[i][p]             = 1'b1;
      req_addr[i][p*AW +: AW]  = AW'(a);
      req_wdata[i][p*DW +: DW] = d;
      req_be[i][p*BW +: BW]    = be;
   endtask

   // Reference behaviour at one rising edge: reads see pre-edge contents, then writes in port order.
   task automatic model_edge();
      exp_t e;
      int   a;
      for (int i = 0; i < 2; i++) begin
         if (!rst[i] && mrdy[i]) begin
            for (int p = 0; p < NP; p++) begin
               if (req_valid[i][p] && !req_we[i][p]) begin
                  a      = int'(req_addr[i][p*AW +: AW]);
                  e.inst = i;
                  e.port = p;
                  e.due  = cyc + lat(i);
                  if (a < dep(i)) begin
                     e.data = mm[i][a];
                     e.err  = 1'b0;
                  end else begin
                     e.data = 32'h0;
                     e.err  = 1'b1;
                  end
                  sb.push_back(e);
               end
            end
            for (int p = 0; p < NP; p++) begin
               a = int'(req_addr[i][p*AW +: AW]);
               if (req_valid[i][p] && req_we[i][p] && a < dep(i)) begin
                  for (int b = 0; b < BW; b++) begin
                     if (req_be[i][p*BW + b]) mm[i][a][b*8 +: 8] = req_wdata[i][p*DW + b*8 +: 8];
                  end
               end
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (rst[i]) begin
            mcnt[i] = 0;
            mrdy[i] = 1'b0;
         end else if (!mrdy[i]) begin
            mcnt[i]++;
            if (mcnt[i] == dep(i)) begin
               mrdy[i] = 1'b1;
               for (int w = 0; w < 16; w++) mm[i][w] = initv(i);
            end
         end
      end
      cyc++;
   endtask

   task automatic check_out();
      logic [63:0] ex;
      logic [63:0] ob;
      int          idx;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("ready i%0d cyc%0d", i, cyc), 64'(ready[i]), 64'(mrdy[i]));
         for (int p = 0; p < NP; p++) begin
            idx = -1;
            for (int k = 0; k < sb.size() && idx < 0; k++) begin
               if (sb[k].inst == i && sb[k].port == p && sb[k].due == cyc) idx = k;
            end
            ex = '0;
            if (idx >= 0) ex = {30'b0, 1'b1, sb[idx].err, sb[idx].data};
            ob = {30'b0, rsp_valid[i][p], rsp_err[i][p], rsp_rdata[i][p*DW +: DW]};
            chk($sformatf("rsp{vld,err,data} i%0d p%0d cyc%0d", i, p, cyc), ob, ex);
            if (idx >= 0) sb.delete(idx);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      idle();
      check_out();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      cyc    = 0;
      rst    = '{1'b1, 1'b1};
      mrdy   = '{1'b0, 1'b0};
      mcnt   = '{0, 0};
      idle();
      repeat (2) step();
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      repeat (16) step();

      // Whole array of instance 0 reads back as the clear value.
      for (int a = 0; a < 16; a += 2) begin
         rd(0, 0, a);
         rd(0, 1, a + 1);
         step();
      end
      step();

      wr(0, 0, 5, 32'hDEADBEEF, 4'hF);
      step();
      rd(0, 0, 5);
      step();
      step();

      wr(0, 0, 3, 32'h11223344, 4'b0011);
      wr(0, 1, 3, 32'hAABBCCDD, 4'b0110);
      step();
      rd(0, 1, 3);
      step();
      step();

      wr(0, 0, 7, 32'h12345678, 4'hF);
      step();
      rd(0, 0, 7);
      wr(0, 1, 7, 32'h5, 4'hF);
      step();
      rd(0, 0, 7);
      step();
      step();

      wr(0, 0, 9, 32'h01020304, 4'hF);
      wr(0, 1, 9, 32'hF0E0D0C0, 4'b1001);
      step();
      wr(0, 0, 5, 32'hFFFFFFFF, 4'h0);
      rd(0, 1, 9);
      step();
      rd(0, 0, 5);
      rd(0, 1, 3);
      step();
      step();

      // Instance 1: out-of-range reads/writes around DEPTH=12.
      rd(1, 0, 13);
      rd(1, 1, 11);
      step();
      wr(1, 0, 13, 32'hCAFEF00D, 4'hF);
      wr(1, 1, 12, 32'h0BADF00D, 4'hF);
      step();
      rd(1, 0, 12);
      rd(1, 1, 15);
      step();
      for (int a = 0; a < 12; a += 2) begin
         rd(1, 0, a);
         rd(1, 1, a + 1);
         step();
      end
      repeat (3) step();

      wr(1, 0, 2, 32'h0BADCAFE, 4'hF);
      step();
      rd(1, 0, 2);
      step();
      repeat (3) step();

      // Reset with three reads in flight on instance 1.
      rd(1, 0, 0);
      rd(1, 1, 1);
      step();
      rd(1, 0, 2);
      step();
      rst[1] = 1'b1;
      for (int k = sb.size() - 1; k >= 0; k--) begin
         if (sb[k].inst == 1) sb.delete(k);
      end
      mrdy[1] = 1'b0;
      mcnt[1] = 0;
      #1;
      chk("async rst ready", 64'(ready[1]), 64'(0));
      chk("async rst rsp_valid", 64'(rsp_valid[1]), 64'(0));
      step();
      step();
      rst[1] = 1'b0;
      wr(1, 1, 4, 32'h44444444, 4'hF);
      rd(1, 0, 5);
      step();
      repeat (11) step();
      rd(1, 0, 2);
      rd(1, 1, 4);
      step();
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
